// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a bundle queue and epoch-tagged ROM reads.
// Drives a synchronous ROM (MEM_LAT cycles of latency), buffers up to QDEPTH returned
// bundles, presents one bundle per advance to decode, and flushes on branch redirect.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   interlock, fetch_stall         decode hold / pipeline stall (freeze output register)
//   redirect_valid, redirect_pc    restart fetch at redirect_pc (bundle-aligned)
//   imem_addr, imem_rdata          ROM address out, ROM data in (MEM_LAT cycles later)
//   pc, inst_to_the_next           bundle PC and bundle to decode (lane 0 = lowest address)
//   inst_valid                     1 = fetched bundle, 0 = NOP bubble
module fetch_queue #(
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        ISSUE    = 2,
    parameter int unsigned        PC_W     = 32,
    parameter int unsigned        MEM_LAT  = 1,
    parameter int unsigned        QDEPTH   = 4,
    parameter logic [INST_W-1:0]  NOP      = INST_W'(32'hE0000000),
    parameter logic [PC_W-1:0]    RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      interlock,
    input  logic                      fetch_stall,
    input  logic                      redirect_valid,
    input  logic [PC_W-1:0]           redirect_pc,
    output logic [PC_W-1:0]           imem_addr,
    input  logic [ISSUE*INST_W-1:0]   imem_rdata,
    output logic [PC_W-1:0]           pc,
    output logic [ISSUE*INST_W-1:0]   inst_to_the_next,
    output logic                      inst_valid
);

    localparam int unsigned BW    = ISSUE * INST_W;
    localparam int unsigned BYTES = BW / 8;
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned INF_W = $clog2(MEM_LAT + 1);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(BYTES - 1);
    localparam logic [BW-1:0]   NOPS       = {ISSUE{NOP}};

    // Fetch address, epoch and output registers
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic             epoch_q, epoch_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [BW-1:0]    inst_q, inst_d;
    logic             valid_q, valid_d;

    // Bundle queue
    logic [BW-1:0]    q_data_q [QDEPTH];
    logic [PC_W-1:0]  q_pc_q   [QDEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // In-flight read tags, index 0 = newest, MEM_LAT-1 = returning this cycle
    logic [MEM_LAT-1:0]           tag_vld_q;
    logic [MEM_LAT-1:0]           tag_ep_q;
    logic [MEM_LAT-1:0][PC_W-1:0] tag_pc_q;

    logic             adv_c;
    logic             fire_c;
    logic             push_c;
    logic             pop_c;
    logic [INF_W-1:0] inflight_c;

    assign imem_addr        = fetch_pc_q;
    assign pc               = pc_q;
    assign inst_to_the_next = inst_q;
    assign inst_valid       = valid_q;

    // Count outstanding reads (stale-epoch ones still hold a credit until they exit)
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            inflight_c = inflight_c + INF_W'(tag_vld_q[i]);
        end
    end

    // Request/return/pop qualifiers; redirect overrides all of them
    always_comb begin
        adv_c  = ~fetch_stall & ~interlock;
        fire_c = ~redirect_valid
                 & ((32'(count_q) + 32'(inflight_c)) < QDEPTH);
        push_c = ~redirect_valid & tag_vld_q[MEM_LAT-1]
                 & (tag_ep_q[MEM_LAT-1] == epoch_q);
        pop_c  = ~redirect_valid & adv_c & (count_q != '0);
    end

    // Next-state for fetch pointer, queue pointers and output register
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            epoch_d    = ~epoch_q;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inst_d     = NOPS;
            valid_d    = 1'b0;
        end else begin
            if (fire_c) begin
                fetch_pc_d = fetch_pc_q + PC_W'(BYTES);
            end
            if (push_c) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop_c) begin
                head_d  = head_q + PTR_W'(1);
                pc_d    = q_pc_q[head_q];
                inst_d  = q_data_q[head_q];
                valid_d = 1'b1;
            end else if (adv_c) begin
                inst_d  = NOPS;
                valid_d = 1'b0;
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pc_q       <= '0;
            inst_q     <= NOPS;
            valid_q    <= 1'b0;
            tag_vld_q  <= '0;
            tag_ep_q   <= '0;
            tag_pc_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            for (int i = int'(MEM_LAT) - 1; i > 0; i--) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_ep_q[i]  <= tag_ep_q[i-1];
                tag_pc_q[i]  <= tag_pc_q[i-1];
            end
            tag_vld_q[0] <= fire_c;
            tag_ep_q[0]  <= epoch_q;
            tag_pc_q[0]  <= fetch_pc_q;
        end
    end

    // Queue storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            q_data_q[tail_q] <= imem_rdata;
            q_pc_q[tail_q]   <= tag_pc_q[MEM_LAT-1];
        end
    end

    // Credits bound count+inflight to QDEPTH, so a return never meets a full queue
    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
        push_c |-> (count_q != CNT_W'(QDEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: ROM model (word at address A = A), queue-based reference model,
// directed scenarios with literal expectations, then randomized stall/interlock/redirect/reset.
module tb_fetch_queue;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned ISSUE   = 2;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned MEM_LAT = 1;
    localparam int unsigned QDEPTH  = 4;
    localparam int unsigned BW      = ISSUE * INST_W;
    localparam int unsigned STEP    = BW / 8;
    localparam logic [INST_W-1:0] NOP  = 32'hE0000000;
    localparam logic [BW-1:0]     NOPS = {ISSUE{NOP}};

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              interlock = 1'b0;
    logic              fetch_stall = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic [PC_W-1:0]   imem_addr;
    logic [BW-1:0]     imem_rdata;
    logic [PC_W-1:0]   pc;
    logic [BW-1:0]     inst_to_the_next;
    logic              inst_valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .INST_W(INST_W), .ISSUE(ISSUE), .PC_W(PC_W), .MEM_LAT(MEM_LAT),
        .QDEPTH(QDEPTH), .NOP(NOP), .RESET_PC('0)
    ) dut (
        .clk(clk), .rstn(rstn), .interlock(interlock), .fetch_stall(fetch_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
        .inst_to_the_next(inst_to_the_next), .inst_valid(inst_valid)
    );

    function automatic logic [BW-1:0] rom_word(input logic [PC_W-1:0] a);
        logic [BW-1:0] r;
        for (int i = 0; i < int'(ISSUE); i++) begin
            r[i*INST_W +: INST_W] = INST_W'(a + PC_W'(i * 4));
        end
        return r;
    endfunction

    // Synchronous ROM with MEM_LAT cycles of latency
    logic [PC_W-1:0] addr_pipe [MEM_LAT];
    always @(posedge clk) begin
        for (int i = int'(MEM_LAT) - 1; i > 0; i--) addr_pipe[i] <= addr_pipe[i-1];
        addr_pipe[0] <= imem_addr;
    end
    assign imem_rdata = rom_word(addr_pipe[MEM_LAT-1]);

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a read issued in cycle C lands in the queue at the end of
    // C+MEM_LAT unless a redirect happened since (tracked as a generation count)
    typedef struct {
        logic [PC_W-1:0] pc;
        int              due;
        int              gen;
    } req_t;

    req_t            infl[$];
    logic [PC_W-1:0] mq[$];
    logic [PC_W-1:0] m_fetch_pc;
    logic [PC_W-1:0] m_pc;
    logic [BW-1:0]   m_inst;
    logic            m_valid;
    int              m_cyc = 0;
    int              m_gen = 0;
    bit              m_adv, m_fire, m_pop;
    req_t            m_req;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            infl.delete();
            mq.delete();
            m_fetch_pc = '0;
            m_pc       = '0;
            m_inst     = NOPS;
            m_valid    = 1'b0;
        end else begin
            m_adv  = !fetch_stall && !interlock;
            m_fire = !redirect_valid && (mq.size() + infl.size() < int'(QDEPTH));
            m_pop  = !redirect_valid && m_adv && (mq.size() > 0);
            if (redirect_valid) begin
                mq.delete();
                m_gen++;
                m_fetch_pc = redirect_pc & ~PC_W'(STEP - 1);
                m_inst     = NOPS;
                m_valid    = 1'b0;
            end else begin
                if (m_pop) begin
                    m_pc    = mq[0];
                    m_inst  = rom_word(mq[0]);
                    m_valid = 1'b1;
                    void'(mq.pop_front());
                end else if (m_adv) begin
                    m_inst  = NOPS;
                    m_valid = 1'b0;
                end
                if (infl.size() > 0 && infl[0].due == m_cyc && infl[0].gen == m_gen)
                    mq.push_back(infl[0].pc);
                if (m_fire) begin
                    m_req.pc  = m_fetch_pc;
                    m_req.due = m_cyc + int'(MEM_LAT);
                    m_req.gen = m_gen;
                    infl.push_back(m_req);
                    m_fetch_pc = m_fetch_pc + PC_W'(STEP);
                end
            end
            if (infl.size() > 0 && infl[0].due == m_cyc) void'(infl.pop_front());
            m_cyc++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("imem_addr", BW'(imem_addr), BW'(m_fetch_pc));
        chk("inst_valid", BW'(inst_valid), BW'(m_valid));
        chk("inst", inst_to_the_next, m_inst);
        chk("pc", BW'(pc), BW'(m_pc));
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset, check reset values, release; returns at the start of cycle 0
    task automatic do_reset();
        rstn = 1'b0;
        fetch_stall = 1'b0; interlock = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", BW'(imem_addr), '0);
        chk("rst_pc", BW'(pc), '0);
        chk("rst_valid", BW'(inst_valid), '0);
        chk("rst_inst", inst_to_the_next, NOPS);
        next_cycle();
        rstn = 1'b1;
    endtask

    logic [PC_W-1:0] last_pc;
    bit              have_last;

    initial begin
        #1;
        // Streaming from reset
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) chk("t1_addr0", BW'(imem_addr), BW'(32'd0));
            if (c == 1) chk("t1_addr1", BW'(imem_addr), BW'(32'd8));
            if (c == 2) chk("t1_addr2", BW'(imem_addr), BW'(32'd16));
            if (c == 3) begin
                chk("t1_pc3", BW'(pc), BW'(32'd0));
                chk("t1_inst3", inst_to_the_next, 64'h00000004_00000000);
                chk("t1_valid3", BW'(inst_valid), BW'(1'b1));
            end
            if (c == 4) begin
                chk("t1_pc4", BW'(pc), BW'(32'd8));
                chk("t1_inst4", inst_to_the_next, 64'h0000000C_00000008);
            end
            if (c == 5) chk("t1_pc5", BW'(pc), BW'(32'd16));
            next_cycle();
        end

        // Stall fills the queue and parks fetch
        do_reset();
        for (int c = 0; c < 16; c++) begin
            fetch_stall = (c >= 2 && c <= 9);
            @(negedge clk);
            if (c == 5) chk("t2_park5", BW'(imem_addr), BW'(32'd32));
            if (c == 9) begin
                chk("t2_park9", BW'(imem_addr), BW'(32'd32));
                chk("t2_frozen", BW'(inst_valid), BW'(1'b0));
            end
            if (c == 11) chk("t2_pc11", BW'(pc), BW'(32'd0));
            if (c == 12) chk("t2_pc12", BW'(pc), BW'(32'd8));
            if (c == 15) begin
                chk("t2_pc15", BW'(pc), BW'(32'd32));
                chk("t2_inst15", inst_to_the_next, 64'h00000024_00000020);
            end
            next_cycle();
        end
        fetch_stall = 1'b0;

        // Redirect mid-stream
        do_reset();
        for (int c = 0; c < 12; c++) begin
            redirect_valid = (c == 6);
            redirect_pc    = 32'h104;
            @(negedge clk);
            if (c == 7) begin
                chk("t3_valid7", BW'(inst_valid), BW'(1'b0));
                chk("t3_inst7", inst_to_the_next, NOPS);
                chk("t3_addr7", BW'(imem_addr), BW'(32'h100));
            end
            if (c == 8 || c == 9) chk("t3_nostale", BW'(inst_valid), BW'(1'b0));
            if (c == 10) begin
                chk("t3_pc10", BW'(pc), BW'(32'h100));
                chk("t3_valid10", BW'(inst_valid), BW'(1'b1));
            end
            next_cycle();
        end
        redirect_valid = 1'b0;

        // Redirect while stalled with a full queue
        do_reset();
        for (int c = 0; c < 15; c++) begin
            fetch_stall    = (c >= 2 && c <= 11);
            redirect_valid = (c == 8);
            redirect_pc    = 32'h200;
            @(negedge clk);
            if (c == 9) begin
                chk("t4_addr9", BW'(imem_addr), BW'(32'h200));
                chk("t4_valid9", BW'(inst_valid), BW'(1'b0));
            end
            if (c == 13) chk("t4_pc13", BW'(pc), BW'(32'h200));
            if (c == 14) chk("t4_pc14", BW'(pc), BW'(32'h208));
            next_cycle();
        end
        fetch_stall = 1'b0; redirect_valid = 1'b0;

        // Interlock every other cycle: each new bundle is exactly +8
        do_reset();
        have_last = 1'b0;
        for (int c = 0; c < 40; c++) begin
            interlock = c[0];
            @(negedge clk);
            if (inst_valid) begin
                if (have_last && pc != last_pc) chk("t5_step", BW'(pc), BW'(last_pc + 32'd8));
                last_pc   = pc;
                have_last = 1'b1;
            end
            next_cycle();
        end
        interlock = 1'b0;
        chk("t5_progress", BW'(have_last), BW'(1'b1));

        // Mid-stream asynchronous reset
        do_reset();
        for (int c = 0; c < 5; c++) next_cycle();
        rstn = 1'b0;
        #1;
        chk("t6_addr", BW'(imem_addr), '0);
        chk("t6_pc", BW'(pc), '0);
        chk("t6_valid", BW'(inst_valid), '0);
        chk("t6_inst", inst_to_the_next, NOPS);
        next_cycle();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("t6_pc3", BW'(pc), BW'(32'd0));
                chk("t6_valid3", BW'(inst_valid), BW'(1'b1));
            end
            next_cycle();
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rstn           = ($urandom_range(0, 399) != 0);
            fetch_stall    = ($urandom_range(0, 3) == 0);
            interlock      = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = PC_W'($urandom);
            next_cycle();
        end
        rstn = 1'b1; fetch_stall = 1'b0; interlock = 1'b0; redirect_valid = 1'b0;
        repeat (4) next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
